// File: rtl/cadder_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : cadder_rr_sched
//  Purpose  : Round-robin scheduler in front of one shared combinational
//             complex adder. At most one requester is granted per cycle; its
//             complex sum is registered with the requester ID into a single
//             output slot that is drained with valid/ready handshaking.
//  Ports    : clk, rst         - clock (rising edge), sync active-high reset
//             req_valid[N]     - per-requester operation valid
//             req_ready[N]     - per-requester accept, one-hot or zero
//             req_a/b_real/img - packed operands, requester i at [i*DATA_W +: DATA_W]
//             out_valid/ready  - result slot handshake
//             out_real/img     - registered sum (modulo 2^DATA_W)
//             out_id           - index of the requester that produced the result
//             op_count         - issued-operation counter, wraps at 2^CNT_W
//  Revision : 1.0 - initial release
// ============================================================================
module cadder_rr_sched #(
    parameter int DATA_W = 32,
    parameter int N_REQ  = 4,
    parameter int ID_W   = $clog2(N_REQ),
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a_real,
    input  logic [N_REQ*DATA_W-1:0] req_a_img,
    input  logic [N_REQ*DATA_W-1:0] req_b_real,
    input  logic [N_REQ*DATA_W-1:0] req_b_img,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_real,
    output logic [DATA_W-1:0]       out_img,
    output logic [ID_W-1:0]         out_id,
    output logic [CNT_W-1:0]        op_count
);

    localparam logic [ID_W-1:0] c_last_id = ID_W'(N_REQ - 1);

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_real;
    logic [DATA_W-1:0] r_out_img;
    logic [ID_W-1:0]   r_out_id;
    logic [CNT_W-1:0]  r_op_count;
    logic [ID_W-1:0]   r_ptr;

    logic              w_slot_free;
    logic              w_any;
    logic [ID_W-1:0]   w_gnt;
    logic              w_issue;
    logic [N_REQ-1:0]  w_gnt_oh;
    logic [ID_W-1:0]   w_ptr_next;
    logic [DATA_W-1:0] w_sum_real;
    logic [DATA_W-1:0] w_sum_img;

    // The slot can take a new result when empty or being drained this cycle.
    assign w_slot_free = !r_out_valid || out_ready;

    // Scan from the priority pointer upward, wrapping modulo N_REQ; the
    // first valid requester wins.
    always_comb begin
        int              v_idx;
        logic [ID_W-1:0] v_sel;
        w_any = 1'b0;
        w_gnt = '0;
        v_idx = 0;
        v_sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= N_REQ) begin
                v_idx = v_idx - N_REQ;
            end
            v_sel = ID_W'(v_idx);
            if (!w_any && req_valid[v_sel]) begin
                w_any = 1'b1;
                w_gnt = v_sel;
            end
        end
    end

    // A grant is only raised towards a valid requester, so granting is
    // the same as a completed transfer. Reset suppresses any handshake.
    assign w_issue   = !rst && w_slot_free && w_any;
    assign w_gnt_oh  = N_REQ'(1) << w_gnt;
    assign req_ready = w_issue ? w_gnt_oh : '0;

    assign w_ptr_next = (w_gnt == c_last_id) ? '0 : w_gnt + ID_W'(1);

    // Shared adder: carry out of each component is discarded.
    assign w_sum_real = req_a_real[w_gnt*DATA_W +: DATA_W] + req_b_real[w_gnt*DATA_W +: DATA_W];
    assign w_sum_img  = req_a_img[w_gnt*DATA_W +: DATA_W]  + req_b_img[w_gnt*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_real  <= '0;
            r_out_img   <= '0;
            r_out_id    <= '0;
            r_op_count  <= '0;
            r_ptr       <= '0;
        end else if (w_issue) begin
            // Covers simultaneous consume+issue: slot is overwritten, no bubble.
            r_out_valid <= 1'b1;
            r_out_real  <= w_sum_real;
            r_out_img   <= w_sum_img;
            r_out_id    <= w_gnt;
            r_op_count  <= r_op_count + CNT_W'(1);
            r_ptr       <= w_ptr_next;
        end else if (out_ready) begin
            // Consume without issue: data registers keep their last values.
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_real  = r_out_real;
    assign out_img   = r_out_img;
    assign out_id    = r_out_id;
    assign op_count  = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_cadder_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cadder_rr_sched
//  Purpose  : Directed self-checking bench for cadder_rr_sched (N_REQ=4,
//             DATA_W=32, CNT_W=16) with hand-computed expected values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cadder_rr_sched;

    localparam int c_data_w = 32;
    localparam int c_n_req  = 4;
    localparam int c_id_w   = 2;
    localparam int c_cnt_w  = 16;

    logic                        clk;
    logic                        rst;
    logic [c_n_req-1:0]          req_valid;
    logic [c_n_req-1:0]          req_ready;
    logic [c_n_req*c_data_w-1:0] req_a_real;
    logic [c_n_req*c_data_w-1:0] req_a_img;
    logic [c_n_req*c_data_w-1:0] req_b_real;
    logic [c_n_req*c_data_w-1:0] req_b_img;
    logic                        out_valid;
    logic                        out_ready;
    logic [c_data_w-1:0]         out_real;
    logic [c_data_w-1:0]         out_img;
    logic [c_id_w-1:0]           out_id;
    logic [c_cnt_w-1:0]          op_count;

    int n_vec = 0;
    int n_err = 0;

    cadder_rr_sched #(
        .DATA_W(c_data_w),
        .N_REQ (c_n_req),
        .ID_W  (c_id_w),
        .CNT_W (c_cnt_w)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a_real(req_a_real),
        .req_a_img (req_a_img),
        .req_b_real(req_b_real),
        .req_b_img (req_b_img),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_img   (out_img),
        .out_id    (out_id),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [31:0] ar, input logic [31:0] ai,
                           input logic [31:0] br, input logic [31:0] bi);
        req_a_real[i*c_data_w +: c_data_w] = ar;
        req_a_img [i*c_data_w +: c_data_w] = ai;
        req_b_real[i*c_data_w +: c_data_w] = br;
        req_b_img [i*c_data_w +: c_data_w] = bi;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] re,
                           input logic [31:0] im, input logic [1:0] id, input logic [15:0] cnt);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".real"},  64'(out_real),  64'(re));
        chk({tag, ".img"},   64'(out_img),   64'(im));
        chk({tag, ".id"},    64'(out_id),    64'(id));
        chk({tag, ".cnt"},   64'(op_count),  64'(cnt));
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        out_ready  = 1'b0;
        req_a_real = '0;
        req_a_img  = '0;
        req_b_real = '0;
        req_b_img  = '0;
        step();
        // Ready must be held low while in reset even with requests pending.
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        step();
        chk_out("rst", 1'b0, 32'd0, 32'd0, 2'd0, 16'd0);

        // Single request on requester 0: (5,-3)+(7,10) = (12,7).
        rst       = 1'b0;
        req_valid = 4'b0001;
        set_ops(0, 32'd5, 32'hFFFF_FFFD, 32'd7, 32'd10);
        #1;
        chk("single_ready", 64'(req_ready), 64'h1);
        step();
        req_valid = '0;
        chk_out("single", 1'b1, 32'd12, 32'd7, 2'd0, 16'd1);

        // Overflow wrap on requester 1 (ptr now 1).
        set_ops(1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd2, 32'h8000_0000);
        req_valid = 4'b0010;
        #1;
        chk("ovf_ready", 64'(req_ready), 64'h2);
        step();
        req_valid = '0;
        chk_out("ovf", 1'b1, 32'd1, 32'd0, 2'd1, 16'd2);

        // Consume with no request: valid drops, data holds.
        step();
        chk_out("consume", 1'b0, 32'd1, 32'd0, 2'd1, 16'd2);

        // Reset, then load distinct operands: requester i -> (101*i, 1000+i).
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < c_n_req; i++) begin
            set_ops(i, 32'(i * 100), 32'(i), 32'(i), 32'd1000);
        end

        // Fairness: all valid for 8 cycles.
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            chk_out($sformatf("rr%0d", k), 1'b1, 32'((k % 4) * 101), 32'(1000 + (k % 4)),
                    2'(k % 4), 16'(k + 1));
        end

        // Backpressure: result from requester 3 pending, out_ready low.
        out_ready = 1'b0;
        req_valid = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d_ready", k), 64'(req_ready), 64'h0);
            step();
            chk_out($sformatf("stall%0d", k), 1'b1, 32'd303, 32'd1003, 2'd3, 16'd8);
        end
        out_ready = 1'b1;
        #1;
        chk("release_ready", 64'(req_ready), 64'h2);
        step();
        chk_out("release", 1'b1, 32'd101, 32'd1001, 2'd1, 16'd9);

        // Pointer skip: ptr=2, only 3 valid -> grant 3.
        req_valid = 4'b1000;
        #1;
        chk("skip3_ready", 64'(req_ready), 64'h8);
        step();
        chk_out("skip3", 1'b1, 32'd303, 32'd1003, 2'd3, 16'd10);
        // ptr wrapped to 0, only 2 valid -> grant 2.
        req_valid = 4'b0100;
        #1;
        chk("skip2_ready", 64'(req_ready), 64'h4);
        step();
        chk_out("skip2", 1'b1, 32'd202, 32'd1002, 2'd2, 16'd11);
        // ptr=3, requesters 0 and 2 valid -> scan 3,0 -> grant 0.
        req_valid = 4'b0101;
        #1;
        chk("skip0_ready", 64'(req_ready), 64'h1);
        step();
        chk_out("skip0", 1'b1, 32'd0, 32'd1000, 2'd0, 16'd12);

        // Mid-operation reset with all requesting: nothing is accepted.
        rst       = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("midrst_ready", 64'(req_ready), 64'h0);
        step();
        rst = 1'b0;
        chk("midrst.valid", 64'(out_valid), 64'h0);
        chk("midrst.cnt",   64'(op_count),  64'h0);
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'h1);
        step();
        req_valid = '0;
        chk_out("post_rst", 1'b1, 32'd0, 32'd1000, 2'd0, 16'd1);
        step();
        chk("drain.valid", 64'(out_valid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cadder_rr_sched.md
Name: cadder_rr_sched

Overview:
- Round-robin scheduler that shares one combinational complex adder among N_REQ requesters in the Karatsuba/QFT datapath.
- Arbitrates requests and issues at most one complex addition per cycle.
- Registers the sum with the winning requester's ID into a single output slot with valid/ready backpressure.
- Sits between the butterfly/partial-product stages and the shared complex-add resource.

Parameters:
- DATA_W, 32, width of each real/imag component (two's complement, modulo 2^DATA_W).
- N_REQ, 4, number of requesters (at least 2).
- ID_W, $clog2(N_REQ), width of the requester ID on the result.
- CNT_W, 16, width of the issued-operation counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operation valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_a_real  in  N_REQ*DATA_W  operand A real, requester i at bits [i*DATA_W +: DATA_W].
- req_a_img  in  N_REQ*DATA_W  operand A imag, same packing.
- req_b_real  in  N_REQ*DATA_W  operand B real, same packing.
- req_b_img  in  N_REQ*DATA_W  operand B imag, same packing.
- out_valid  out  1  result slot holds a result.
- out_ready  in  1  downstream accepts the result.
- out_real  out  DATA_W  registered sum, real part.
- out_img  out  DATA_W  registered sum, imag part.
- out_id  out  ID_W  index of the requester that produced the result.
- op_count  out  CNT_W  number of issued operations, wraps at 2^CNT_W.

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, out_real=0, out_img=0, out_id=0, op_count=0, priority pointer=0 (requester 0 highest).
- req_ready is combinational and is 0 during reset.
- Slot free: slot_free = !out_valid || out_ready.
- Grant:
  - If slot_free and any req_valid, grant the first valid requester scanning from ptr upward, modulo N_REQ.
  - req_ready[g]=1 for the granted requester only; all other bits are 0.
  - If the slot is not free, req_ready is all zero.
- Transfer: occurs when req_valid[i] && req_ready[i]. Requesters must hold operands stable while valid and not ready.
- Issue (on transfer, at the next edge):
  - out_real <= (a_real + b_real) mod 2^DATA_W and out_img <= (a_img + b_img) mod 2^DATA_W; the carry out is discarded.
  - out_id <= g, out_valid <= 1.
  - ptr <= (g+1) mod N_REQ.
  - op_count <= op_count + 1, wrapping from 2^CNT_W-1 to 0.
- Latency: one cycle from transfer to out_valid.
- Throughput: one operation per cycle while out_ready=1.
- Simultaneous consume and issue (out_valid=1, out_ready=1, transfer this cycle): the slot is overwritten with the new result and out_valid stays 1. There is no bubble.
- Consume without issue: out_valid <= 0. Data registers hold their last values.
- Stall (out_valid=1, out_ready=0): the output registers, ptr and op_count all hold. No grant is issued.
- No requests: ptr holds and no state changes except consume.
- Fairness: with all requesters continuously valid and out_ready=1, grants cycle 0,1,...,N_REQ-1,0,...
- Wrap-around of ptr: after a grant to N_REQ-1, the scan starts at 0.
- Reset mid-operation: a pending result is dropped (out_valid=0), ptr returns to 0, and any requester handshaking that cycle is not accepted.
- Output-side protocol: out_real, out_img and out_id are stable while out_valid=1 and out_ready=0.

Test Plan:
- Reset then single request: req_valid=0001, a=(5,-3), b=(7,10), out_ready=1 -> req_ready=0001 in the same cycle. Next cycle: out_valid=1, out_real=12, out_img=7, out_id=0, op_count=1.
- Overflow wrap: DATA_W=32, a_real=32'hFFFF_FFFF, b_real=2, a_img=32'h8000_0000, b_img=32'h8000_0000 -> out_real=1, out_img=0.
- Round-robin fairness: req_valid=1111 held for 8 cycles, out_ready=1 -> out_id sequence 0,1,2,3,0,1,2,3 and op_count=8.
- Backpressure:
  - Result pending, out_ready=0 for 3 cycles, req_valid=0110 -> req_ready=0000 and outputs stable for all 3 cycles.
  - Then out_ready=1 -> grant goes to requester 1 in that same cycle, and the new result appears next cycle with out_valid held at 1.
- Pointer skip: after a grant to 3, req_valid=0100 -> grant 2. Then with req_valid=0101 -> grant 0 (ptr=3 scans 3,0).
- Mid-operation reset: out_valid=1 with op_count=5, assert rst for one cycle while req_valid=1111 -> next cycle out_valid=0 and op_count=0. The first grant after reset is requester 0.
